// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state, opcode, funct and select encodings for the multicycle controller
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
endpackage

// File: rtl/alu_funct_decoder.sv
// alu_funct_decoder: maps an R-type funct field to its ALU operation and flags unsupported functs
module alu_funct_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       funct_valid
);
  assign alu_control = funct == FN_SUB ? ALU_SUB :
                       funct == FN_AND ? ALU_AND :
                       funct == FN_OR  ? ALU_OR  :
                       funct == FN_SLT ? ALU_SLT : ALU_ADD;
  assign funct_valid = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: sequencing FSM driving the multicycle MIPS datapath with memory wait states
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       Illegal,
  output logic [3:0] State
);
  state_t     state, state_n;
  logic [2:0] funct_alu;
  logic       funct_valid;
  logic       legal;
  alu_funct_decoder u_dec (
    .funct       (Funct),
    .alu_control (funct_alu),
    .funct_valid (funct_valid)
  );
  assign legal = Op inside {OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J} || (Op == OP_RTYPE && funct_valid);
  assign State = state;
  // State register and sticky illegal-instruction flag
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state   <= S_FETCH;
      Illegal <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_DECODE && !legal) Illegal <= 1'b1;
    end
  end
  // Next-state selection; unreachable codes fall back to FETCH
  always_comb begin
    state_n = S_FETCH;
    case (state)
      S_FETCH:    state_n = MemReady ? S_DECODE : S_FETCH;
      S_DECODE:   state_n = (Op == OP_LW || Op == OP_SW)       ? S_MEMADR  :
                            (Op == OP_RTYPE && funct_valid)    ? S_EXECUTE :
                            Op == OP_BEQ                       ? S_BRANCH  :
                            Op == OP_ADDI                      ? S_ADDIEX  :
                            Op == OP_J                         ? S_JUMP    :
                            HALT_ON_ILLEGAL                    ? S_HALT    : S_FETCH;
      S_MEMADR:   state_n = Op == OP_SW ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_n = MemReady ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_n = MemReady ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  state_n = S_ALUWB;
      S_ADDIEX:   state_n = S_ADDIWB;
      S_HALT:     state_n = S_HALT;
      default:    state_n = S_FETCH;
    endcase
  end
  // Datapath controls decoded from state; enables are suppressed while reset is held
  always_comb begin
    PCEn       = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemToReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    ALUControl = ALU_ADD;
    PCSrc      = PC_ALU;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = MemReady;
        PCEn    = MemReady;
      end
      S_DECODE:   ALUSrcB = SRCB_IMMSH;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEMWB: begin
        MemToReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUControl = funct_alu;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = PC_ALUOUT;
        PCEn       = Zero;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_ADDIWB:   RegWrite = 1'b1;
      S_JUMP: begin
        PCSrc = PC_JUMP;
        PCEn  = 1'b1;
      end
      default: ;
    endcase
    if (RESET) begin
      PCEn     = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      MemRead  = 1'b0;
    end
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed and randomized instruction streams checked against an instruction-level model
module tb_multicycle_controller;
  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic [5:0] Op = 6'd0;
  logic [5:0] Funct = 6'd0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite, ALUSrcA, Illegal;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;
  logic       h_PCEn, h_IorD, h_MemRead, h_MemWrite, h_IRWrite, h_RegDst, h_MemToReg, h_RegWrite, h_ALUSrcA, h_Illegal;
  logic [1:0] h_ALUSrcB, h_PCSrc;
  logic [2:0] h_ALUControl;
  logic [3:0] h_State;
  int checks = 0;
  int errors = 0;
  logic ill_exp = 1'b0;
  logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  typedef struct {int st; bit mr;} step_t;

  multicycle_controller #(.HALT_ON_ILLEGAL(1'b0)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc), .Illegal(Illegal), .State(State)
  );
  multicycle_controller #(.HALT_ON_ILLEGAL(1'b1)) dut_h (
    .CLOCK(CLOCK), .RESET(RESET), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .PCEn(h_PCEn), .IorD(h_IorD), .MemRead(h_MemRead), .MemWrite(h_MemWrite), .IRWrite(h_IRWrite),
    .RegDst(h_RegDst), .MemToReg(h_MemToReg), .RegWrite(h_RegWrite), .ALUSrcA(h_ALUSrcA),
    .ALUSrcB(h_ALUSrcB), .ALUControl(h_ALUControl), .PCSrc(h_PCSrc), .Illegal(h_Illegal), .State(h_State)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'bxxx;
    endcase
  endfunction

  function automatic bit is_legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'b000000) return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    return op inside {6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  // k: 0 lw, 1 sw, 2 R-type, 3 beq, 4 addi, 5 j, 6 illegal. Entry/exit: 2 time units after a rising edge, FSM in FETCH.
  task automatic run_instr(input int k, input logic [5:0] op, input logic [5:0] fn, input logic z, input int fw, input int mw);
    step_t q[$];
    int rw = 0, mwc = 0, pe = 0, ir = 0, mrc = 0;
    Op = op;
    Funct = fn;
    Zero = z;
    for (int i = 0; i < fw; i++) q.push_back('{0, 1'b0});
    q.push_back('{0, 1'b1});
    q.push_back('{1, rb()});
    case (k)
      0: begin
        q.push_back('{2, rb()});
        for (int i = 0; i < mw; i++) q.push_back('{3, 1'b0});
        q.push_back('{3, 1'b1});
        q.push_back('{4, rb()});
      end
      1: begin
        q.push_back('{2, rb()});
        for (int i = 0; i < mw; i++) q.push_back('{5, 1'b0});
        q.push_back('{5, 1'b1});
      end
      2: begin q.push_back('{6, rb()}); q.push_back('{7, rb()}); end
      3: q.push_back('{8, rb()});
      4: begin q.push_back('{9, rb()}); q.push_back('{10, rb()}); end
      5: q.push_back('{11, rb()});
      default: ;
    endcase
    foreach (q[i]) begin
      MemReady = q[i].mr;
      #1;
      chk("state", State, q[i].st);
      chk("illegal", Illegal, ill_exp);
      rw += RegWrite; mwc += MemWrite; pe += PCEn; ir += IRWrite; mrc += MemRead;
      case (q[i].st)
        0: begin
          chk("fetch_ctl", {IorD, ALUSrcA, ALUSrcB, PCSrc, ALUControl}, {1'b0, 1'b0, 2'b01, 2'b00, 3'b010});
          chk("fetch_en", {IRWrite, PCEn}, {q[i].mr, q[i].mr});
        end
        3: chk("memread", {IorD, MemRead, MemWrite}, 3'b110);
        4: chk("memwb", {RegDst, MemToReg, RegWrite}, 3'b011);
        5: chk("memwrite", {IorD, MemRead, MemWrite, RegWrite}, 4'b1010);
        6: chk("execute", {ALUSrcA, ALUSrcB, ALUControl}, {1'b1, 2'b00, alu_of(fn)});
        7: chk("aluwb", {RegDst, MemToReg, RegWrite}, 3'b101);
        8: chk("branch", {ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn}, {1'b1, 2'b00, 3'b110, 2'b01, z});
        10: chk("addiwb", {RegDst, MemToReg, RegWrite}, 3'b001);
        11: chk("jump", {PCSrc, PCEn}, 3'b101);
        default: ;
      endcase
      if (q[i].st == 1 && k == 6) ill_exp = 1'b1;
      @(posedge CLOCK);
      #2;
    end
    chk("next_fetch", State, 0);
    chk("irwrite_cnt", ir, 1);
    chk("pcen_cnt", pe, ((k == 3 && z) || k == 5) ? 2 : 1);
    chk("regwrite_cnt", rw, (k == 0 || k == 2 || k == 4) ? 1 : 0);
    chk("memwrite_cnt", mwc, k == 1 ? mw + 1 : 0);
    chk("memread_cnt", mrc, fw + 1 + (k == 0 ? mw + 1 : 0));
  endtask

  task automatic run_random(input int n, input bit allow_illegal);
    for (int j = 0; j < n; j++) begin
      int k;
      logic [5:0] op, fn;
      k = allow_illegal ? $urandom_range(0, 6) : $urandom_range(0, 5);
      fn = fns[$urandom_range(0, 4)];
      case (k)
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: op = 6'b000000;
        3: op = 6'b000100;
        4: op = 6'b001000;
        5: op = 6'b000010;
        default: begin
          op = 6'($urandom_range(0, 1) ? 0 : $urandom_range(0, 63));
          fn = 6'($urandom_range(0, 63));
          while (is_legal(op, fn)) fn = 6'($urandom_range(0, 63));
        end
      endcase
      if (k != 2 && k != 6) fn = 6'($urandom_range(0, 63));
      run_instr(k, op, fn, rb(), $urandom_range(0, 2), $urandom_range(0, 3));
    end
  endtask

  initial begin
    MemReady = 1'b1;
    #3;
    chk("rst_state", State, 0);
    chk("rst_illegal", Illegal, 0);
    chk("rst_en", {PCEn, IRWrite, RegWrite, MemWrite, MemRead}, 5'b0);
    @(posedge CLOCK);
    #2;
    RESET = 1'b0;
    #1;
    chk("rst_release_en", {IRWrite, PCEn}, 2'b11);
    run_instr(0, 6'b100011, 6'd0, 1'b0, 0, 0);
    run_instr(1, 6'b101011, 6'd0, 1'b0, 0, 3);
    run_instr(2, 6'b000000, 6'b101010, 1'b0, 0, 0);
    run_instr(2, 6'b000000, 6'b100010, 1'b0, 0, 0);
    run_instr(3, 6'b000100, 6'd0, 1'b1, 0, 0);
    run_instr(3, 6'b000100, 6'd0, 1'b0, 0, 0);
    run_instr(5, 6'b000010, 6'd0, 1'b0, 0, 0);
    Op = 6'b100011;
    for (int i = 0; i < 3; i++) begin
      MemReady = 1'b1;
      @(posedge CLOCK);
      #2;
    end
    MemReady = 1'b0;
    #1;
    chk("abort_in_memread", State, 3);
    #2;
    RESET = 1'b1;
    #1;
    chk("abort_state", State, 0);
    chk("abort_en", {PCEn, IRWrite, RegWrite, MemWrite, MemRead}, 5'b0);
    @(posedge CLOCK);
    #2;
    MemReady = 1'b1;
    #1;
    chk("abort_held_state", State, 0);
    chk("abort_held_en", {PCEn, IRWrite, RegWrite, MemWrite, MemRead}, 5'b0);
    RESET = 1'b0;
    #1;
    chk("abort_release_en", {IRWrite, PCEn}, 2'b11);
    run_random(40, 1'b0);
    run_instr(6, 6'b111111, 6'd0, 1'b0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      MemReady = 1'b0;
      Zero = rb();
      #1;
      chk("halt_state", h_State, 12);
      chk("halt_en", {h_PCEn, h_IRWrite, h_RegWrite, h_MemWrite, h_MemRead}, 5'b0);
      chk("halt_illegal", h_Illegal, 1);
      chk("wait_fetch", State, 0);
      @(posedge CLOCK);
      #2;
    end
    run_instr(4, 6'b001000, 6'd0, 1'b0, 0, 0);
    run_random(40, 1'b1);
    RESET = 1'b1;
    #1;
    chk("final_rst_illegal", {Illegal, h_Illegal}, 2'b00);
    chk("final_rst_state", {State, h_State}, 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequencing FSM for the multicycle variant of the MIPS core: one shared instruction/data memory, IR/ALUOut registers, one ALU reused for PC increment, branch target and execute.
- Drives every mux select and write enable of that datapath from the latched Op/Funct fields and the ALU Zero flag.
- Inserts wait states on a MemReady handshake so a slow or arbitrated memory can be attached without datapath changes.

Parameters:
- HALT_ON_ILLEGAL, 0, 0: an illegal instruction returns to FETCH. 1: the FSM enters HALT and stays there until RESET.

Ports:
- CLOCK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- Op  in  6  IR[31:26]
- Funct  in  6  IR[5:0]
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory completes the current access this cycle
- PCEn  out  1  PC register load enable
- IorD  out  1  0: memory address = PC. 1: memory address = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load enable
- RegDst  out  1  0: write reg = rt. 1: write reg = rd
- MemToReg  out  1  0: register write data = ALUOut. 1: register write data = memory data
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  0: ALU A = PC. 1: ALU A = register A
- ALUSrcB  out  2  00: register B. 01: constant 4. 10: SignImm. 11: SignImm<<2
- ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- PCSrc  out  2  00: ALU result. 01: ALUOut. 10: jump target
- Illegal  out  1  sticky flag for an unsupported opcode or funct
- State  out  4  current state, for debug

Behaviour:
- State register
  - Registered; next state is combinational.
  - Outputs are decoded from State. The only input-qualified outputs are PCEn, IRWrite and the wait-state exits.
- Reset
  - RESET high asynchronously forces State=FETCH and Illegal=0.
  - While RESET is high, PCEn, IRWrite, RegWrite, MemWrite and MemRead are forced to 0.
  - Reset mid-instruction aborts the instruction; no partial writes occur after RESET rises.
- Default output values (any output not listed for a state): 0, ALUControl=010.
- Per-state outputs and transitions:
  - FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, add, PCSrc=00, IRWrite=PCEn=MemReady. Go to DECODE when MemReady=1, else stay.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, add. Next state by opcode:
    - 100011 lw / 101011 sw -> MEMADR
    - 000000 R-type with Funct in {100000, 100010, 100100, 100101, 101010} -> EXECUTE
    - 000100 beq -> BRANCH
    - 001000 addi -> ADDIEX
    - 000010 j -> JUMP
    - any other encoding -> set Illegal, then FETCH (HALT if HALT_ON_ILLEGAL=1)
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, add. Go to MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD(3): IorD=1, MemRead=1. Hold until MemReady=1, then MEMWB.
  - MEMWB(4): RegDst=0, MemToReg=1, RegWrite=1. Go to FETCH.
  - MEMWRITE(5): IorD=1, MemWrite=1, held for the whole wait. Hold until MemReady=1, then FETCH.
  - EXECUTE(6): ALUSrcA=1, ALUSrcB=00. Funct mapping:
    - 100000 -> 010
    - 100010 -> 110
    - 100100 -> 000
    - 100101 -> 001
    - 101010 -> 111
    - Go to ALUWB.
  - ALUWB(7): RegDst=1, MemToReg=0, RegWrite=1. Go to FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, PCEn=Zero. Go to FETCH.
  - ADDIEX(9): ALUSrcA=1, ALUSrcB=10, add. Go to ADDIWB.
  - ADDIWB(10): RegDst=0, MemToReg=0, RegWrite=1. Go to FETCH.
  - JUMP(11): PCSrc=10, PCEn=1. Go to FETCH.
  - HALT(12): all enables 0. Stay until RESET.
  - Codes 13-15 are unreachable. If entered, go to FETCH next cycle with all enables 0.
- Instruction latency, assuming MemReady is always 1:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type and addi: 4 cycles
  - beq and j: 3 cycles
  - Each cycle of MemReady=0 adds one cycle.
- MemReady is ignored outside FETCH, MEMREAD and MEMWRITE.
- Illegal is sticky: once set it holds until RESET, including across later legal instructions.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state codes
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - funct constants
  - ALUControl encodings
  - ALUSrcB and PCSrc select encodings
- One sub-module, alu_funct_decoder: combinational, Funct -> {ALUControl, funct_valid}. Used by EXECUTE and by the illegal check in DECODE.

Test Plan:
- Reset: assert RESET asynchronously mid-MEMREAD -> State=0, all enables 0 before the next CLOCK edge. Release with MemReady=1 -> IRWrite=PCEn=1 in the first cycle.
- lw (Op=100011), MemReady=1 -> state sequence 0,1,2,3,4. In state 4, RegWrite=1, MemToReg=1, RegDst=0. Total 5 cycles.
- sw with MemReady low for 3 cycles in MEMWRITE -> MemWrite=1 for 4 consecutive cycles, IorD=1, then FETCH. RegWrite never 1.
- R-type Funct=101010 -> EXECUTE drives ALUControl=111, ALUWB drives RegDst=1, RegWrite=1. Repeat with Funct=100010 -> ALUControl=110.
- beq with Zero=1 -> PCEn=1, PCSrc=01 in state 8. beq with Zero=0 -> PCEn=0. j -> PCEn=1, PCSrc=10 in state 11. Each takes 3 cycles.
- Op=111111 -> Illegal=1 after DECODE, next state FETCH. Illegal stays 1 through a following addi. With HALT_ON_ILLEGAL=1 -> State=12 held for 10 cycles with all enables 0.
